mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  1  M-extension op valid from EX stage; held high until a cycle with stall=0.
REQ-005 funct3  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 a, b  input  DATA_WIDTH  rs1, rs2.
REQ-007 flush  input  1  pipeline kill; aborts the in-flight op.
REQ-008 o  output  DATA_WIDTH  rd result; valid when req=1 and stall=0.
REQ-009 stall  output  1  holds the pipeline.
REQ-010 mul_req, mul_opcode[1:0], mul_a, mul_b  output  request, opcode and operands to the external pipelined multiplier.
REQ-011 mul_o  input  DATA_WIDTH, mul_stall  input  1  multiplier result and busy.

Function
REQ-012 States: IDLE, MUL_BUSY, MUL_DRAIN, DIV_RUN, DIV_FIN; rst forces IDLE.
REQ-013 IDLE, req=1, funct3[2]=0, flush=0: mul_req=1, mul_opcode=funct3[1:0], mul_a=a, mul_b=b, stall=mul_stall, next MUL_BUSY.
REQ-014 MUL_BUSY: mul_req=req, stall=mul_stall, o=mul_o; on stall=0 next IDLE.
REQ-015 Multiply latency is defined entirely by the multiplier; mdu_ctrl adds no cycles.
REQ-016 IDLE, req=1, funct3[2]=1, no special case: latch |a|, |b| (signed ops) or raw values (unsigned ops), latch result signs, set count=DATA_WIDTH, stall=1, next DIV_RUN.
REQ-017 DIV_RUN: one restoring-division step per cycle, MSB first; count decrements; stall=1; next DIV_FIN after DATA_WIDTH cycles.
REQ-018 DIV_FIN: apply sign fix; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Drive o = quotient (DIV/DIVU) or remainder (REM/REMU); stall=0; next IDLE.
REQ-019 Full divide: stall high 1+DATA_WIDTH cycles; result in cycle DATA_WIDTH+1 after acceptance.
REQ-020 Divide by zero, b=0: quotient all ones, remainder = a; IDLE goes directly to DIV_FIN; result in cycle 1.
REQ-021 Signed overflow, DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient 0x80000000, remainder 0; IDLE goes directly to DIV_FIN.
REQ-022 flush=1 has priority in every state; stall=0 in that cycle; result discarded.
REQ-023 On flush, DIV_RUN and DIV_FIN go to IDLE. MUL_BUSY goes to MUL_DRAIN if mul_stall=1, else IDLE.
REQ-024 MUL_DRAIN: mul_req=0; stall=req; go to IDLE when mul_stall=0; new req not accepted until IDLE.
REQ-025 mul_req=0 in all states other than IDLE and MUL_BUSY; o=0 when no result is valid.

Reset
REQ-026 On rst: state=IDLE, count=0, stall=0, mul_req=0, o=0, reuse entry invalid; rst mid-divide abandons the op without a result.

Configuration
REQ-027 The feature is controlled by macro MDU_REUSE_EN.
REQ-028 MDU_REUSE_EN defined: a one-entry cache stores a, b, signedness (funct3[0]), quotient and remainder of the last completed divide.
REQ-029 With MDU_REUSE_EN, a divide/rem request hitting the cache goes IDLE to DIV_FIN (result in cycle 1).
REQ-030 With MDU_REUSE_EN, the cache entry is invalidated on flush, on rst, and on any aborted divide.
REQ-031 MDU_REUSE_EN undefined: no cache logic; every non-special divide takes the full REQ-019 latency.

Verification
REQ-032 MUL, a=7, b=-3, with a 2-stage multiplier model -> o=0xFFFFFFEB; stall pattern matches the model exactly.
REQ-033 DIVU, a=100, b=7 -> stall high 33 cycles, then o=14; REMU with the same operands -> o=2.
REQ-034 DIV a=-7, b=2 -> o=0xFFFFFFFD; REM a=-7, b=2 -> o=0xFFFFFFFF.
REQ-035 Special cases: DIV a=5, b=0 -> o=0xFFFFFFFF in cycle 1; REM a=5, b=0 -> o=5; DIV a=0x80000000, b=0xFFFFFFFF -> o=0x80000000.
REQ-036 flush at cycle 10 of DIV_RUN -> stall=0 that cycle; IDLE next cycle; a following DIVU 9/3 -> o=3 after full latency.
REQ-037 With MDU_REUSE_EN: DIV 100/7 then REM 100/7 -> second result in cycle 1, o=2. Without the macro: 33 stall cycles.

Source files
------------

// File: rtl/mdu_ctrl.sv
// RV32M multiply/divide controller: multiplies go to an external pipelined multiplier,
// divides run on a local restoring divider. Optional last-divide reuse cache: MDU_REUSE_EN.
module mdu_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] o,
    output logic                  stall,
    output logic                  mul_req,
    output logic [1:0]            mul_opcode,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    input  logic [DATA_WIDTH-1:0] mul_o,
    input  logic                  mul_stall
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL_BUSY, MUL_DRAIN, DIV_RUN, DIV_FIN} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] quo, rem, dvsr;
    logic                  q_neg, r_neg, sel_rem;

    logic                  is_div, sgn, a_neg, b_neg, div_zero, ovf, hit;
    logic [DATA_WIDTH-1:0] abs_a, abs_b, q_fix, r_fix, div_res, hit_q, hit_r;
    logic [DATA_WIDTH:0]   r_sh, diff;

    assign is_div   = funct3[2];
    assign sgn      = ~funct3[0];
    assign a_neg    = sgn & a[DATA_WIDTH-1];
    assign b_neg    = sgn & b[DATA_WIDTH-1];
    assign abs_a    = a_neg ? -a : a;
    assign abs_b    = b_neg ? -b : b;
    assign div_zero = (b == '0);
    assign ovf      = sgn && (a == MIN_NEG) && (b == '1);

    // Partial remainder shifted left with the next dividend bit; borrow in the top bit.
    assign r_sh = {rem, quo[DATA_WIDTH-1]};
    assign diff = r_sh - {1'b0, dvsr};

    assign q_fix   = q_neg ? -quo : quo;
    assign r_fix   = r_neg ? -rem : rem;
    assign div_res = sel_rem ? r_fix : q_fix;

`ifdef MDU_REUSE_EN
    logic                  c_vld, c_uns, p_uns;
    logic [DATA_WIDTH-1:0] c_a, c_b, c_q, c_r, p_a, p_b;

    assign hit   = c_vld && (c_a == a) && (c_b == b) && (c_uns == funct3[0]);
    assign hit_q = c_q;
    assign hit_r = c_r;

    // Operands are captured at acceptance and committed with the sign-fixed results.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            c_vld <= 1'b0;
        end else begin
            if (state == IDLE && req && is_div) begin
                p_a   <= a;
                p_b   <= b;
                p_uns <= funct3[0];
            end
            if (state == DIV_FIN) begin
                c_vld <= 1'b1;
                c_a   <= p_a;
                c_b   <= p_b;
                c_uns <= p_uns;
                c_q   <= q_fix;
                c_r   <= r_fix;
            end
        end
    end
`else
    assign hit   = 1'b0;
    assign hit_q = '0;
    assign hit_r = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else if (flush) begin
            count <= '0;
            // A killed multiply must still drain out of the external pipeline.
            state <= ((state == MUL_BUSY || state == MUL_DRAIN) && mul_stall) ? MUL_DRAIN : IDLE;
        end else begin
            case (state)
                IDLE: if (req) begin
                    if (!is_div) begin
                        if (mul_stall) state <= MUL_BUSY;
                    end else begin
                        sel_rem <= funct3[1];
                        if (div_zero) begin
                            quo   <= '1;
                            rem   <= a;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= DIV_FIN;
                        end else if (ovf) begin
                            quo   <= MIN_NEG;
                            rem   <= '0;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= DIV_FIN;
                        end else if (hit) begin
                            quo   <= hit_q;
                            rem   <= hit_r;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= DIV_FIN;
                        end else begin
                            quo   <= abs_a;
                            rem   <= '0;
                            dvsr  <= abs_b;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            count <= CW'(DATA_WIDTH);
                            state <= DIV_RUN;
                        end
                    end
                end
                MUL_BUSY, MUL_DRAIN: if (!mul_stall) state <= IDLE;
                DIV_RUN: begin
                    if (!diff[DATA_WIDTH]) begin
                        rem <= diff[DATA_WIDTH-1:0];
                        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= r_sh[DATA_WIDTH-1:0];
                        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
                    end
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= DIV_FIN;
                end
                DIV_FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall   = 1'b0;
        o       = '0;
        mul_req = 1'b0;
        if (!rst && !flush) begin
            case (state)
                IDLE: if (req) begin
                    if (!is_div) begin
                        mul_req = 1'b1;
                        stall   = mul_stall;
                        if (!mul_stall) o = mul_o;
                    end else begin
                        stall = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    mul_req = req;
                    stall   = mul_stall;
                    if (!mul_stall) o = mul_o;
                end
                MUL_DRAIN: stall = req;
                DIV_RUN:   stall = 1'b1;
                DIV_FIN:   o = div_res;
                default:   stall = 1'b0;
            endcase
        end
    end

    assign mul_opcode = funct3[1:0];
    assign mul_a      = a;
    assign mul_b      = b;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed + random bench for mdu_ctrl against an arithmetic RV32M reference and a
// 2-stage multiplier model; expected latencies follow the controller's timing rules.
module tb_mdu_ctrl;
    localparam int DW   = 32;
    localparam int MLAT = 2;

    logic          clk = 1'b0;
    logic          rst, req, flush, stall, mul_req, mul_stall;
    logic [2:0]    funct3;
    logic [1:0]    mul_opcode;
    logic [DW-1:0] a, b, o, mul_a, mul_b, mul_o;

    int ncmp = 0;
    int nerr = 0;

    // Reference cache of the last completed divide (only consulted when the feature is built).
    bit            cv = 1'b0;
    bit            cu = 1'b0;
    logic [DW-1:0] ca = '0, cb = '0;

    always #5 clk = ~clk;

    mdu_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .funct3(funct3), .a(a), .b(b), .flush(flush),
        .o(o), .stall(stall), .mul_req(mul_req), .mul_opcode(mul_opcode),
        .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o), .mul_stall(mul_stall)
    );

    function automatic logic [31:0] mul_ref(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (op)
            2'd0, 2'd1: p = 64'(sx * sy);
            2'd2:       p = 64'(sx * uy);
            default:    p = 64'(ux * uy);
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] div_ref(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x;
        sy = y;
        if (y == 0) return f[1] ? x : 32'hFFFF_FFFF;
        if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return f[1] ? 32'h0 : x;
        if (f[0]) return f[1] ? x % y : x / y;
        return f[1] ? 32'(sx % sy) : 32'(sx / sy);
    endfunction

    // Stall cycles before the result cycle.
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2]) return MLAT;
        if (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`ifdef MDU_REUSE_EN
        if (cv && ca == x && cb == y && cu == f[0]) return 1;
`endif
        return DW + 1;
    endfunction

    // Multiplier model: busy for MLAT cycles from the first cycle of a request.
    int            age = 0;
    logic [1:0]    m_op;
    logic [DW-1:0] m_a, m_b;
    assign mul_stall = mul_req && (age < MLAT);
    assign mul_o     = (mul_req && age >= MLAT) ? mul_ref(m_op, m_a, m_b) : '0;
    always @(posedge clk) begin
        if (rst || !mul_req || !mul_stall) begin
            age <= 0;
        end else begin
            if (age == 0) begin
                m_op <= mul_opcode;
                m_a  <= mul_a;
                m_b  <= mul_b;
            end
            age <= age + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input string tag);
        int n, lat;
        logic [31:0] e;
        lat = exp_lat(f, x, y);
        e   = f[2] ? div_ref(f, x, y) : mul_ref(f[1:0], x, y);
        @(posedge clk); #1;
        req = 1'b1; funct3 = f; a = x; b = y;
        n = 0;
        @(negedge clk);
        if (!f[2]) begin
            check({tag, ".mul_req"}, 32'(mul_req), 32'd1);
            check({tag, ".mul_opcode"}, 32'(mul_opcode), 32'(f[1:0]));
        end
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, ".lat"}, 32'(n), 32'(lat));
        check({tag, ".o"}, o, e);
        if (f[2]) begin
            cv = 1'b1; ca = x; cb = y; cu = f[0];
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] rx, ry;
        rst = 1'b1; req = 1'b1; flush = 1'b0; funct3 = 3'd4; a = 32'd5; b = 32'd0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.o", o, 32'd0);
        check("rst.mul_req", 32'(mul_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        check("idle.stall", 32'(stall), 32'd0);
        check("idle.o", o, 32'd0);

        do_op(3'd0, 32'd7, -32'sd3, "mul_7x-3");
        do_op(3'd5, 32'd100, 32'd7, "divu_100_7");
        do_op(3'd7, 32'd100, 32'd7, "remu_100_7");
        do_op(3'd4, -32'sd7, 32'd2, "div_-7_2");
        do_op(3'd6, -32'sd7, 32'd2, "rem_-7_2");
        do_op(3'd4, 32'd5, 32'd0, "div_by0");
        do_op(3'd6, 32'd5, 32'd0, "rem_by0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        do_op(3'd4, 32'd100, 32'd7, "div_100_7");
        do_op(3'd6, 32'd100, 32'd7, "rem_100_7_reuse");

        // Flush in the tenth cycle of the iterative divide.
        @(posedge clk); #1;
        req = 1'b1; funct3 = 3'd4; a = 32'd1000; b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("flush.pre_stall", 32'(stall), 32'd1);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush.stall", 32'(stall), 32'd0);
        check("flush.o", o, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req = 1'b0; cv = 1'b0;
        @(negedge clk);
        check("flush.idle_stall", 32'(stall), 32'd0);
        do_op(3'd5, 32'd9, 32'd3, "divu_9_3_after_flush");

        // Flush racing a multiply request in IDLE.
        @(posedge clk); #1;
        req = 1'b1; funct3 = 3'd0; flush = 1'b1;
        @(negedge clk);
        check("flush_idle.stall", 32'(stall), 32'd0);
        check("flush_idle.mul_req", 32'(mul_req), 32'd0);
        @(posedge clk); #1;
        req = 1'b0; flush = 1'b0; cv = 1'b0;

        do_op(3'd5, 32'd9, 32'd3, "divu_9_3_warm");
        // Reset mid-divide: no result, cache dropped.
        @(posedge clk); #1;
        req = 1'b1; funct3 = 3'd5; a = 32'd50; b = 32'd6;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid.stall", 32'(stall), 32'd0);
        check("rst_mid.o", o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; cv = 1'b0;
        @(negedge clk);
        check("rst_mid.idle", 32'(stall), 32'd0);
        do_op(3'd5, 32'd9, 32'd3, "divu_9_3_after_rst");

        for (int k = 0; k < 60; k++) begin
            rf = 3'($urandom_range(0, 7));
            rx = $urandom;
            case ($urandom_range(0, 9))
                0:       ry = 32'd0;
                1:       begin ry = 32'hFFFF_FFFF; rx = 32'h8000_0000; end
                2:       begin rx = ca; ry = cb; end
                3:       ry = 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            do_op(rf, rx, ry, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
